// File: rtl/spi_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_rx_pkg
//  Description : Shared types and constants for the uAlfat SPI byte reader:
//                transfer state encoding, output FIFO depth and the dummy
//                byte clocked out on MOSI while reading.
//  Revision    : 1.0  initial release
// ============================================================================
package spi_rx_pkg;

    // Transfer sequencer states
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEL_SETUP = 3'd1,
        SHIFT     = 3'd2,
        SEL_HOLD  = 3'd3,
        GAP       = 3'd4
    } spi_state_t;

    // Entries in the output store when the FIFO build option is enabled
    localparam int c_FIFO_DEPTH = 4;

    // Byte presented on MOSI during reads; the uAlfat ignores it
    localparam logic [7:0] c_DUMMY_BYTE = 8'h00;

endpackage : spi_rx_pkg
`default_nettype wire

// File: rtl/spi_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : spi_rx_fifo
//  Description : Output store for received bytes. DEPTH=1 builds a single
//                holding register; larger depths build a circular FIFO.
//                Push and pop in the same cycle both take effect.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_rx_fifo
    import spi_rx_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             valid,
    output logic             full
);

    logic             w_valid;
    logic             w_full;
    logic [WIDTH-1:0] w_rd_data;
    logic             w_do_pop;
    logic             w_do_push;

    // A pop needs data present; a push is accepted when there is room or when
    // the head leaves in the same cycle
    assign w_do_pop  = pop && w_valid;
    assign w_do_push = push && (!w_full || w_do_pop);

    generate
        if (DEPTH == 1) begin : g_single
            logic [WIDTH-1:0] r_data;
            logic             r_valid;

            // Single holding register with a valid flag
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data  <= '0;
                    r_valid <= 1'b0;
                end else begin
                    if (w_do_push) begin
                        r_data <= push_data;
                    end
                    if (w_do_push) begin
                        r_valid <= 1'b1;
                    end else if (w_do_pop) begin
                        r_valid <= 1'b0;
                    end
                end
            end

            assign w_rd_data = r_data;
            assign w_valid   = r_valid;
            assign w_full    = r_valid;
        end else begin : g_multi
            localparam int c_PTR_W = $clog2(DEPTH);
            localparam int c_CNT_W = $clog2(DEPTH + 1);

            logic [WIDTH-1:0]   r_mem [DEPTH];
            logic [c_PTR_W-1:0] r_wr_ptr;
            logic [c_PTR_W-1:0] r_rd_ptr;
            logic [c_CNT_W-1:0] r_count;

            // Circular buffer with separate read/write pointers and occupancy
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_mem[i] <= '0;
                    end
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_count  <= '0;
                end else begin
                    if (w_do_push) begin
                        r_mem[r_wr_ptr] <= push_data;
                        r_wr_ptr <= (r_wr_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
                    end
                    if (w_do_pop) begin
                        r_rd_ptr <= (r_rd_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
                    end
                    if (w_do_push && !w_do_pop) begin
                        r_count <= r_count + 1'b1;
                    end else if (w_do_pop && !w_do_push) begin
                        r_count <= r_count - 1'b1;
                    end
                end
            end

            assign w_rd_data = r_mem[r_rd_ptr];
            assign w_valid   = (r_count != '0);
            assign w_full    = (r_count == c_CNT_W'(DEPTH));
        end
    endgenerate

    assign rd_data = w_rd_data;
    assign valid   = w_valid;
    assign full    = w_full;

endmodule : spi_rx_fifo
`default_nettype wire

// File: rtl/spi_rx_reader.sv
`default_nettype none
// ============================================================================
//  Module      : spi_rx_reader
//  Description : SPI mode-3 master that reads single bytes from a uAlfat
//                whenever it signals data ready, and hands them to a
//                valid/ready consumer through an output store.
//                Build option SPI_RX_FIFO_EN: 4-entry output FIFO instead of
//                a single holding register.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_rx_reader
    import spi_rx_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SPI_DATARDY,
    input  logic        SPI_BUSY,
    input  logic        SPI_MISO,
    input  logic        stop,
    output logic        spi_sck,
    output logic        SPI_SSEL,
    output logic        SPI_MOSI,
    output logic [7:0]  dout_byte,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic [15:0] rx_count
);

`ifdef SPI_RX_FIFO_EN
    localparam int c_STORE_DEPTH = c_FIFO_DEPTH;
`else
    localparam int c_STORE_DEPTH = 1;
`endif

    localparam logic [7:0] c_DIV_LAST = 8'(CLK_DIV - 1);

    spi_state_t  r_state;
    logic [7:0]  r_div;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_sck;
    logic        r_ssel;
    logic [15:0] r_rx_count;

    logic        w_div_done;
    logic        w_push;
    logic        w_full;

    assign w_div_done = (r_div == c_DIV_LAST);
    // The byte is complete on the last cycle of the select-hold phase
    assign w_push     = (r_state == SEL_HOLD) && w_div_done;

    // Transfer sequencer: owns the divider, bit counter, shifter and the
    // registered SCK/SSEL pins so they always change together with the state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_div      <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_sck      <= 1'b1;
            r_ssel     <= 1'b1;
            r_rx_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_div <= '0;
                    if (SPI_DATARDY && !SPI_BUSY && !stop && !w_full) begin
                        r_state <= SEL_SETUP;
                        r_ssel  <= 1'b0;
                    end
                end
                SEL_SETUP: begin
                    if (w_div_done) begin
                        r_state   <= SHIFT;
                        r_sck     <= 1'b0;
                        r_div     <= '0;
                        r_bit_cnt <= '0;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                SHIFT: begin
                    if (w_div_done) begin
                        r_div <= '0;
                        if (!r_sck) begin
                            // Rising SCK edge: the slave's bit has been stable
                            // for the whole low phase
                            r_sck   <= 1'b1;
                            r_shift <= {r_shift[6:0], SPI_MISO};
                        end else if (r_bit_cnt == 3'd7) begin
                            r_state <= SEL_HOLD;
                        end else begin
                            r_sck     <= 1'b0;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                SEL_HOLD: begin
                    if (w_div_done) begin
                        r_state    <= GAP;
                        r_ssel     <= 1'b1;
                        r_div      <= '0;
                        r_rx_count <= r_rx_count + 1'b1;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                GAP: begin
                    if (w_div_done) begin
                        r_state <= IDLE;
                        r_div   <= '0;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_div   <= '0;
                    r_sck   <= 1'b1;
                    r_ssel  <= 1'b1;
                end
            endcase
        end
    end

    spi_rx_fifo #(
        .DEPTH (c_STORE_DEPTH),
        .WIDTH (8)
    ) u_store (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (r_shift),
        .pop       (dout_ready),
        .rd_data   (dout_byte),
        .valid     (dout_valid),
        .full      (w_full)
    );

    assign spi_sck  = r_sck;
    assign SPI_SSEL = r_ssel;
    assign SPI_MOSI = c_DUMMY_BYTE[7];
    assign rx_count = r_rx_count;

endmodule : spi_rx_reader
`default_nettype wire

// File: tb/tb_spi_rx_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_rx_reader
//  Description : Self-checking bench for spi_rx_reader with a behavioural
//                uAlfat slave model and a byte scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spi_rx_reader;

    localparam int CLK_DIV = 2;
`ifdef SPI_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        SPI_DATARDY = 1'b0;
    logic        SPI_BUSY = 1'b0;
    logic        SPI_MISO = 1'b0;
    logic        stop = 1'b0;
    logic        spi_sck;
    logic        SPI_SSEL;
    logic        SPI_MOSI;
    logic [7:0]  dout_byte;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic [15:0] rx_count;

    int total = 0;
    int bad = 0;
    int exp_rx = 0;

    logic [7:0] tx_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] cur_byte = 8'h00;
    int         bit_idx = 7;

    int   ssel_falls = 0;
    int   sck_falls = 0;
    logic prev_ssel = 1'b1;
    logic prev_sck = 1'b1;

    spi_rx_reader #(.CLK_DIV(CLK_DIV)) dut (
        .clk         (clk),
        .rst         (rst),
        .SPI_DATARDY (SPI_DATARDY),
        .SPI_BUSY    (SPI_BUSY),
        .SPI_MISO    (SPI_MISO),
        .stop        (stop),
        .spi_sck     (spi_sck),
        .SPI_SSEL    (SPI_SSEL),
        .SPI_MOSI    (SPI_MOSI),
        .dout_byte   (dout_byte),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .rx_count    (rx_count)
    );

    always #5 clk = ~clk;

    // Slave model: a new byte is chosen at select, each SCK fall presents the next bit MSB first
    always @(negedge SPI_SSEL) begin
        if (tx_q.size() > 0) cur_byte = tx_q.pop_front();
        else                 cur_byte = 8'h00;
        exp_q.push_back(cur_byte);
        bit_idx = 7;
    end

    always @(negedge spi_sck) begin
        if (SPI_SSEL === 1'b0 && bit_idx >= 0) begin
            SPI_MISO = cur_byte[bit_idx];
            bit_idx  = bit_idx - 1;
        end
    end

    // Edge counters and scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        if (prev_ssel === 1'b1 && SPI_SSEL === 1'b0) ssel_falls++;
        if (prev_sck === 1'b1 && spi_sck === 1'b0) sck_falls++;
        prev_ssel = SPI_SSEL;
        prev_sck  = spi_sck;
        if (!rst && dout_valid === 1'b1 && dout_ready === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got byte %02h, expected none", dout_byte);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (dout_byte !== e) begin
                    bad++;
                    $display("FAIL sb_byte: got %02h expected %02h", dout_byte, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits until every started byte was consumed and the bus went idle;
    // drops DATARDY once the slave has nothing left to send
    task automatic wait_done(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            tick();
            if (tx_q.size() == 0) SPI_DATARDY = 1'b0;
            if (tx_q.size() == 0 && exp_q.size() == 0 && SPI_SSEL === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (CLK_DIV + 2) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        total++; if (spi_sck !== 1'b1)     begin bad++; $display("FAIL rst_sck: got %b expected 1", spi_sck); end
        total++; if (SPI_SSEL !== 1'b1)    begin bad++; $display("FAIL rst_ssel: got %b expected 1", SPI_SSEL); end
        total++; if (SPI_MOSI !== 1'b0)    begin bad++; $display("FAIL rst_mosi: got %b expected 0", SPI_MOSI); end
        total++; if (dout_byte !== 8'h00)  begin bad++; $display("FAIL rst_dout: got %02h expected 00", dout_byte); end
        total++; if (dout_valid !== 1'b0)  begin bad++; $display("FAIL rst_valid: got %b expected 0", dout_valid); end
        total++; if (rx_count !== 16'h0)   begin bad++; $display("FAIL rst_count: got %0d expected 0", rx_count); end
        rst = 1'b0;
        repeat (3) tick();
        total++; if (SPI_SSEL !== 1'b1)    begin bad++; $display("FAIL idle_ssel: got %b expected 1", SPI_SSEL); end
    endtask

    task automatic test_basic();
        int low = 0, falls = 0, vcyc = 0, mosi_hi = 0;
        logic psck;
        bit ok;
        dout_ready = 1'b1;
        tx_q.push_back(8'hA5);
        SPI_DATARDY = 1'b1;
        psck = spi_sck;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (tx_q.size() == 0) SPI_DATARDY = 1'b0;
            if (SPI_SSEL === 1'b0) low++;
            if (psck === 1'b1 && spi_sck === 1'b0) falls++;
            if (dout_valid === 1'b1) vcyc++;
            if (SPI_MOSI !== 1'b0) mosi_hi++;
            psck = spi_sck;
        end
        exp_rx = 1;
        total++; if (low != 18 * CLK_DIV) begin bad++; $display("FAIL basic_ssel_low: got %0d cycles expected %0d", low, 18 * CLK_DIV); end
        total++; if (falls != 8)          begin bad++; $display("FAIL basic_sck_falls: got %0d expected 8", falls); end
        total++; if (vcyc != 1)           begin bad++; $display("FAIL basic_valid_cycles: got %0d expected 1", vcyc); end
        total++; if (mosi_hi != 0)        begin bad++; $display("FAIL basic_mosi: got %0d high cycles expected 0", mosi_hi); end
        total++; if (rx_count !== 16'(exp_rx)) begin bad++; $display("FAIL basic_count: got %0d expected %0d", rx_count, exp_rx); end
        wait_done(50, ok);
        total++; if (!ok || exp_q.size() != 0) begin bad++; $display("FAIL basic_delivered: pending %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_busy();
        int f0, s0;
        bit ok;
        f0 = ssel_falls; s0 = sck_falls;
        SPI_BUSY = 1'b1;
        SPI_DATARDY = 1'b1;
        repeat (100) tick();
        total++; if (ssel_falls != f0 || SPI_SSEL !== 1'b1) begin bad++; $display("FAIL busy_ssel: got %0d selects expected 0", ssel_falls - f0); end
        total++; if (sck_falls != s0) begin bad++; $display("FAIL busy_sck: got %0d sck edges expected 0", sck_falls - s0); end
        tx_q.push_back(8'h5A);
        SPI_BUSY = 1'b0;
        tick();
        total++; if (SPI_SSEL !== 1'b0) begin bad++; $display("FAIL busy_release: got ssel %b expected 0", SPI_SSEL); end
        wait_done(200, ok);
        exp_rx++;
        total++; if (!ok || rx_count !== 16'(exp_rx)) begin bad++; $display("FAIL busy_count: got %0d expected %0d", rx_count, exp_rx); end
    endtask

    task automatic test_stop();
        int f0;
        bit ok = 1'b0;
        tx_q.push_back(8'h3C);
        SPI_DATARDY = 1'b1;
        for (int i = 0; i < 20 && SPI_SSEL !== 1'b0; i++) tick();
        repeat (10) tick();
        stop = 1'b1;
        SPI_DATARDY = 1'b0;
        tick();
        SPI_DATARDY = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (SPI_SSEL === 1'b1) begin ok = 1'b1; break; end
        end
        f0 = ssel_falls;
        repeat (100) tick();
        exp_rx++;
        total++; if (!ok || exp_q.size() != 0) begin bad++; $display("FAIL stop_complete: pending %0d expected 0", exp_q.size()); end
        total++; if (ssel_falls != f0) begin bad++; $display("FAIL stop_inhibit: got %0d new selects expected 0", ssel_falls - f0); end
        total++; if (rx_count !== 16'(exp_rx)) begin bad++; $display("FAIL stop_count: got %0d expected %0d", rx_count, exp_rx); end
        SPI_DATARDY = 1'b0;
        stop = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int f0, run = 0, min_gap = 1000;
        bit seen = 1'b0, ok;
        f0 = ssel_falls;
        tx_q.push_back(8'hA1); tx_q.push_back(8'hB2); tx_q.push_back(8'hC3);
        SPI_DATARDY = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (SPI_SSEL === 1'b1) run++;
            else begin
                if (seen && run > 0 && run < min_gap) min_gap = run;
                seen = 1'b1;
                run = 0;
            end
            if (tx_q.size() == 0 && SPI_SSEL === 1'b0) SPI_DATARDY = 1'b0;
        end
        wait_done(50, ok);
        exp_rx += 3;
        total++; if (ssel_falls - f0 != 3) begin bad++; $display("FAIL b2b_starts: got %0d expected 3", ssel_falls - f0); end
        total++; if (min_gap != CLK_DIV + 1) begin bad++; $display("FAIL b2b_gap: got %0d cycles expected %0d", min_gap, CLK_DIV + 1); end
        total++; if (!ok || rx_count !== 16'(exp_rx)) begin bad++; $display("FAIL b2b_count: got %0d expected %0d", rx_count, exp_rx); end
    endtask

    task automatic test_fifo();
        int f0;
        bit ok;
        dout_ready = 1'b0;
        f0 = ssel_falls;
        for (int b = 1; b <= 5; b++) tx_q.push_back(8'(b));
        SPI_DATARDY = 1'b1;
        repeat (400) tick();
        total++; if (ssel_falls - f0 != DEPTH) begin bad++; $display("FAIL fifo_fill: got %0d starts expected %0d", ssel_falls - f0, DEPTH); end
        total++; if (dout_valid !== 1'b1 || dout_byte !== 8'h01) begin bad++; $display("FAIL fifo_head: got %02h valid %b expected 01 valid 1", dout_byte, dout_valid); end
        total++; if (SPI_SSEL !== 1'b1) begin bad++; $display("FAIL fifo_no_start: got ssel %b expected 1", SPI_SSEL); end
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        repeat (100) tick();
        total++; if (ssel_falls - f0 != DEPTH + 1) begin bad++; $display("FAIL fifo_resume: got %0d starts expected %0d", ssel_falls - f0, DEPTH + 1); end
        dout_ready = 1'b1;
        wait_done(1500, ok);
        exp_rx += 5;
        total++; if (!ok || exp_q.size() != 0) begin bad++; $display("FAIL fifo_drain: pending %0d expected 0", exp_q.size()); end
        total++; if (rx_count !== 16'(exp_rx)) begin bad++; $display("FAIL fifo_count: got %0d expected %0d", rx_count, exp_rx); end
    endtask

    task automatic test_reset_mid();
        int rises = 0;
        logic psck;
        dout_ready = 1'b1;
        tx_q.push_back(8'hFF);
        SPI_DATARDY = 1'b1;
        psck = spi_sck;
        for (int i = 0; i < 100 && rises < 3; i++) begin
            tick();
            if (psck === 1'b0 && spi_sck === 1'b1) rises++;
            psck = spi_sck;
        end
        rst = 1'b1;
        SPI_DATARDY = 1'b0;
        tick();
        total++; if (rises != 3) begin bad++; $display("FAIL rstmid_bits: got %0d rises expected 3", rises); end
        total++; if (SPI_SSEL !== 1'b1 || spi_sck !== 1'b1) begin bad++; $display("FAIL rstmid_bus: got ssel %b sck %b expected 1 1", SPI_SSEL, spi_sck); end
        total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %b expected 0", dout_valid); end
        total++; if (rx_count !== 16'h0) begin bad++; $display("FAIL rstmid_count: got %0d expected 0", rx_count); end
        exp_q.delete();
        tx_q.delete();
        exp_rx = 0;
        rst = 1'b0;
        repeat (60) tick();
        total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL rstmid_discard: got valid %b expected 0", dout_valid); end
    endtask

    task automatic test_wrap();
        bit ok;
        force dut.r_rx_count = 16'hFFFF;
        tick();
        release dut.r_rx_count;
        tick();
        dout_ready = 1'b1;
        tx_q.push_back(8'h77);
        SPI_DATARDY = 1'b1;
        wait_done(200, ok);
        total++; if (!ok || exp_q.size() != 0) begin bad++; $display("FAIL wrap_byte: pending %0d expected 0", exp_q.size()); end
        total++; if (rx_count !== 16'h0000) begin bad++; $display("FAIL wrap_count: got %04h expected 0000", rx_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_busy();
        test_stop();
        test_back_to_back();
        test_fifo();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_spi_rx_reader
`default_nettype wire
